// File: rtl/lightsout_keyscan.sv
// Column-scanning key front end for the 3x3 lights-out matrix: column strobe,
// per-key debounce, and a 4-deep show-ahead FIFO of press events.
module lightsout_keyscan #(
    parameter int unsigned SCAN_DIV         = 4,
    parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [2:0] BTN_ROW,
    output logic [2:0] COL,
    output logic [1:0] ACTIVE_COL,
    output logic [8:0] KEYS_DOWN,
    output logic       EVT_VALID,
    output logic [3:0] EVT_KEY,
    input  logic       EVT_READY,
    output logic       OVERFLOW
);

    localparam int unsigned PW    = 8;
    localparam int unsigned CW    = 4;
    localparam int unsigned KW    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned NW    = 3;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_SAMPLES - 1);

    logic [PW-1:0] presc;
    logic [CW-1:0] cnt [9];
    logic [2:0]    pend;
    logic [1:0]    pend_col;
    logic [KW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [NW-1:0] count;

    logic          sample_c;
    logic [1:0]    col_n;
    logic [8:0]    keys_n;
    logic [CW-1:0] cnt_n [9];
    logic [2:0]    rise_c;
    logic          push_c;
    logic [KW-1:0] push_key_c;
    logic [2:0]    pend_n;
    logic [1:0]    pend_col_n;
    logic          pop_c;
    logic          accept_c;
    logic [KW-1:0] mem_n [DEPTH];
    logic [AW-1:0] wr_n;
    logic [AW-1:0] rd_n;
    logic [NW-1:0] count_n;

    assign sample_c = (presc == PRESC_LAST);
    assign col_n    = (ACTIVE_COL == 2'd2) ? 2'd0 : ACTIVE_COL + 2'd1;

    // Debounce: only keys in the strobed column are updated at its sample edge.
    always_comb begin
        keys_n = KEYS_DOWN;
        cnt_n  = cnt;
        rise_c = '0;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                if (sample_c && (ACTIVE_COL == 2'(c))) begin
                    if (BTN_ROW[r] == KEYS_DOWN[r*3+c]) begin
                        cnt_n[r*3+c] = '0;
                    end else if (cnt[r*3+c] == CNT_LAST) begin
                        keys_n[r*3+c] = BTN_ROW[r];
                        cnt_n[r*3+c]  = '0;
                        rise_c[r]     = BTN_ROW[r];
                    end else begin
                        cnt_n[r*3+c] = cnt[r*3+c] + CW'(1);
                    end
                end
            end
        end
    end

    // Pending mask drains lowest row first, one push per cycle.
    always_comb begin
        push_c     = |pend;
        push_key_c = '0;
        pend_n     = pend;
        pend_col_n = pend_col;
        if (pend[0]) begin
            push_key_c = KW'(pend_col);
            pend_n[0]  = 1'b0;
        end else if (pend[1]) begin
            push_key_c = KW'(pend_col) + KW'(3);
            pend_n[1]  = 1'b0;
        end else if (pend[2]) begin
            push_key_c = KW'(pend_col) + KW'(6);
            pend_n[2]  = 1'b0;
        end
        if (|rise_c) begin
            pend_n     = pend_n | rise_c;
            pend_col_n = ACTIVE_COL;
        end
    end

    // FIFO: a pop frees a slot for a same-cycle push even when full.
    always_comb begin
        pop_c    = (count != '0) && EVT_READY;
        accept_c = push_c && ((count != NW'(DEPTH)) || pop_c);
        mem_n    = mem;
        if (accept_c) begin
            mem_n[wr_ptr] = push_key_c;
        end
        wr_n    = wr_ptr + AW'(accept_c);
        rd_n    = rd_ptr + AW'(pop_c);
        count_n = count + NW'(accept_c) - NW'(pop_c);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            presc      <= '0;
            ACTIVE_COL <= '0;
            COL        <= 3'b001;
            KEYS_DOWN  <= '0;
            cnt        <= '{default: '0};
            pend       <= '0;
            pend_col   <= '0;
            mem        <= '{default: '0};
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            EVT_VALID  <= 1'b0;
            EVT_KEY    <= '0;
            OVERFLOW   <= 1'b0;
        end else begin
            presc <= sample_c ? '0 : presc + PW'(1);
            if (sample_c) begin
                ACTIVE_COL <= col_n;
                COL        <= 3'b001 << col_n;
            end
            KEYS_DOWN <= keys_n;
            cnt       <= cnt_n;
            pend      <= pend_n;
            pend_col  <= pend_col_n;
            mem       <= mem_n;
            wr_ptr    <= wr_n;
            rd_ptr    <= rd_n;
            count     <= count_n;
            EVT_VALID <= (count_n != '0);
            EVT_KEY   <= mem_n[rd_n];
            OVERFLOW  <= OVERFLOW | (push_c & ~accept_c);
        end
    end

endmodule
